// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: state codes, opcodes, datapath select
// encodings, the control word layout and its idle value.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_H = 3'd1,
    S_FETCH_L = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC1   = 3'd4,
    S_EXEC2   = 3'd5,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_BRA = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_NOT  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  localparam logic [1:0] MUXA_IR  = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b01;
  localparam logic [1:0] MUXA_ARF = 2'b10;
  localparam logic [1:0] MUXA_ALU = 2'b11;

  localparam logic [1:0] MUXB_IR  = 2'b01;
  localparam logic [1:0] MUXB_MEM = 2'b10;
  localparam logic [1:0] MUXB_ALU = 2'b11;

  localparam logic MUXC_RF  = 1'b1;
  localparam logic MUXC_ARF = 1'b0;

  localparam logic [1:0] ADDR_PC = 2'b00;
  localparam logic [1:0] ADDR_AR = 2'b10;
  localparam logic [1:0] ADDR_SP = 2'b11;

  localparam logic [2:0] ARF_EN_PC   = 3'b110;
  localparam logic [2:0] ARF_EN_AR   = 3'b101;
  localparam logic [2:0] ARF_EN_SP   = 3'b011;
  localparam logic [2:0] ARF_EN_NONE = 3'b111;

  typedef struct packed {
    logic [1:0] rf_outa;
    logic [1:0] rf_outb;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu_fun;
    logic [1:0] arf_outc;
    logic [1:0] arf_outd;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    rf_outa:  2'b00,
    rf_outb:  2'b00,
    rf_fun:   2'b00,
    rf_reg:   4'hF,
    alu_fun:  4'h0,
    arf_outc: 2'b00,
    arf_outd: 2'b00,
    arf_fun:  2'b00,
    arf_reg:  ARF_EN_NONE,
    ir_lh:    1'b0,
    ir_en:    1'b0,
    ir_fun:   2'b00,
    mem_wr:   1'b0,
    mem_cs:   1'b1,
    mux_a:    2'b00,
    mux_b:    2'b00,
    mux_c:    1'b0
  };

  // Active-low write enable for one of R1..R4.
  function automatic logic [3:0] rf_enable(input logic [1:0] sel);
    logic [3:0] en;
    en      = 4'hF;
    en[sel] = 1'b0;
    return en;
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_XOR:  code = ALU_XOR;
      OP_NOT:  code = ALU_NOT;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map from the current state and instruction word to the full
// control word; stall/reset gating is applied by the caller.
module control_decode
  import ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  logic [3:0] op;
  logic [1:0] dst;
  logic [1:0] src;
  logic       unused_k;

  assign op  = ir[15:12];
  assign dst = ir[11:10];
  assign src = ir[9:8];
  // K feeds the datapath muxes directly; no control decision depends on it.
  assign unused_k = ^ir[7:0];

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_INIT: begin
        ctrl.arf_fun = FUN_CLR;
        ctrl.arf_reg = ARF_EN_PC;
      end
      S_FETCH_H, S_FETCH_L: begin
        ctrl.arf_outd = ADDR_PC;
        ctrl.mem_cs   = 1'b0;
        ctrl.mem_wr   = 1'b0;
        ctrl.ir_en    = 1'b1;
        ctrl.ir_fun   = FUN_LOAD;
        ctrl.ir_lh    = (state == S_FETCH_L);
        ctrl.arf_fun  = FUN_INC;
        ctrl.arf_reg  = ARF_EN_PC;
      end
      S_EXEC1: begin
        case (op)
          OP_LDI: begin
            ctrl.mux_a  = MUXA_IR;
            ctrl.rf_fun = FUN_LOAD;
            ctrl.rf_reg = rf_enable(dst);
          end
          OP_LDM, OP_ST: begin
            ctrl.mux_b   = MUXB_IR;
            ctrl.arf_fun = FUN_LOAD;
            ctrl.arf_reg = ARF_EN_AR;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            ctrl.rf_outa = dst;
            ctrl.rf_outb = src;
            ctrl.mux_c   = MUXC_RF;
            ctrl.alu_fun = alu_code(op);
            ctrl.mux_a   = MUXA_ALU;
            ctrl.rf_fun  = FUN_LOAD;
            ctrl.rf_reg  = rf_enable(dst);
          end
          OP_INC: begin
            ctrl.rf_fun = FUN_INC;
            ctrl.rf_reg = rf_enable(dst);
          end
          OP_DEC: begin
            ctrl.rf_fun = FUN_DEC;
            ctrl.rf_reg = rf_enable(dst);
          end
          OP_BRA: begin
            ctrl.mux_b   = MUXB_IR;
            ctrl.arf_fun = FUN_LOAD;
            ctrl.arf_reg = ARF_EN_PC;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        case (op)
          OP_LDM: begin
            ctrl.arf_outd = ADDR_AR;
            ctrl.mem_cs   = 1'b0;
            ctrl.mux_a    = MUXA_MEM;
            ctrl.rf_fun   = FUN_LOAD;
            ctrl.rf_reg   = rf_enable(dst);
          end
          OP_ST: begin
            ctrl.rf_outa  = src;
            ctrl.mux_c    = MUXC_RF;
            ctrl.alu_fun  = ALU_PASS;
            ctrl.arf_outd = ADDR_AR;
            ctrl.mem_cs   = 1'b0;
            ctrl.mem_wr   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch two IR bytes, decode, then one or two execute
// cycles; holds the FSM state and gates the decoded control word.
module control_unit
  import ctrl_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [15:0] IR_Out,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SeqCounter,
  output logic        Halted
);

  state_t     state;
  state_t     state_next;
  ctrl_t      dec;
  ctrl_t      ctrl;
  logic       stall_eff;
  logic [3:0] op;

  assign op = IR_Out[15:12];
  // INIT and HALT never freeze, so Stall only matters in the sequencing states.
  assign stall_eff = Stall && (state != S_INIT) && (state != S_HALT);

  control_decode u_decode (
    .state (state),
    .ir    (IR_Out),
    .ctrl  (dec)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:    state_next = S_FETCH_H;
      S_FETCH_H: state_next = S_FETCH_L;
      S_FETCH_L: state_next = S_DECODE;
      S_DECODE:  state_next = S_EXEC1;
      S_EXEC1: begin
        if (op == OP_LDM || op == OP_ST) state_next = S_EXEC2;
        else if (op == OP_HLT)           state_next = S_HALT;
        else if (is_undef(op))           state_next = HALT_ON_UNDEF ? S_HALT : S_FETCH_H;
        else                             state_next = S_FETCH_H;
      end
      S_EXEC2:   state_next = S_FETCH_H;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_INIT;
    endcase
    if (stall_eff) state_next = state;
  end

  assign ctrl = (Reset || stall_eff) ? CTRL_IDLE : dec;

  assign RF_OutASel  = ctrl.rf_outa;
  assign RF_OutBSel  = ctrl.rf_outb;
  assign RF_FunSel   = ctrl.rf_fun;
  assign RF_RegSel   = ctrl.rf_reg;
  assign ALU_FunSel  = ctrl.alu_fun;
  assign ARF_OutCSel = ctrl.arf_outc;
  assign ARF_OutDSel = ctrl.arf_outd;
  assign ARF_FunSel  = ctrl.arf_fun;
  assign ARF_RegSel  = ctrl.arf_reg;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_en;
  assign IR_Funsel   = ctrl.ir_fun;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a;
  assign MuxBSel     = ctrl.mux_b;
  assign MuxCSel     = ctrl.mux_c;
  assign SeqCounter  = Reset ? 3'd0 : state;
  assign Halted      = !Reset && (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: hand-written vector table, directed
// stall/halt/reset sequences, and randomized instructions against a model.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic [15:0] IR_Out = 16'h0000;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SeqCounter;
  logic        Halted;

  int tests = 0;
  int fails = 0;

  control_unit #(.HALT_ON_UNDEF(1'b0)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .IR_Out(IR_Out),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .SeqCounter(SeqCounter), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] oa, ob, rff;
    logic [3:0] rfr, alu;
    logic [1:0] oc, od, arff;
    logic [2:0] arfr;
    logic       lh, ire;
    logic [1:0] irf;
    logic       wr, cs;
    logic [1:0] ma, mb;
    logic       mc;
    logic [2:0] seq;
    logic       halted;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  ph;
    logic [3:0]  rfr;
    logic [1:0]  ma, rff;
    logic [2:0]  arfr;
    logic [1:0]  mb;
    logic        cs, wr;
    logic [1:0]  od, oa;
    logic [3:0]  alu;
  } vec_t;

  function automatic outs_t cap();
    return '{RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
             IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, SeqCounter, Halted};
  endfunction

  function automatic outs_t idle(input logic [2:0] ph);
    outs_t o;
    o = '{2'd0, 2'd0, 2'd0, 4'hF, 4'h0, 2'd0, 2'd0, 2'd0, 3'h7, 1'b0, 1'b0,
          2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0};
    o.seq    = ph;
    o.halted = (ph == 3'd7);
    return o;
  endfunction

  // Expected outputs for a given phase code of an instruction word.
  function automatic outs_t model(input logic [2:0] ph, input logic [15:0] ins);
    outs_t      o;
    logic [3:0] op;
    logic [1:0] d, s;
    logic [3:0] en;
    logic [3:0] alu_tab [0:5];
    o  = idle(ph);
    op = ins[15:12];
    d  = ins[11:10];
    s  = ins[9:8];
    en = 4'hF;
    en[d] = 1'b0;
    alu_tab = '{4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'h2};
    if (ph == 3'd0) begin
      o.arff = 2'b11; o.arfr = 3'b110;
    end else if (ph == 3'd1 || ph == 3'd2) begin
      o.od = 2'b00; o.cs = 1'b0; o.ire = 1'b1; o.irf = 2'b10;
      o.lh = (ph == 3'd2); o.arff = 2'b01; o.arfr = 3'b110;
    end else if (ph == 3'd4) begin
      if (op == 4'h0) begin
        o.ma = 2'b00; o.rff = 2'b10; o.rfr = en;
      end else if (op == 4'h1 || op == 4'h2) begin
        o.mb = 2'b01; o.arff = 2'b10; o.arfr = 3'b101;
      end else if (op >= 4'h3 && op <= 4'h8) begin
        o.oa = d; o.ob = s; o.mc = 1'b1; o.ma = 2'b11; o.rff = 2'b10;
        o.rfr = en; o.alu = alu_tab[op - 4'h3];
      end else if (op == 4'h9) begin
        o.rff = 2'b01; o.rfr = en;
      end else if (op == 4'hA) begin
        o.rff = 2'b00; o.rfr = en;
      end else if (op == 4'hB) begin
        o.mb = 2'b01; o.arff = 2'b10; o.arfr = 3'b110;
      end
    end else if (ph == 3'd5) begin
      if (op == 4'h1) begin
        o.od = 2'b10; o.cs = 1'b0; o.ma = 2'b01; o.rff = 2'b10; o.rfr = en;
      end else if (op == 4'h2) begin
        o.oa = s; o.mc = 1'b1; o.alu = 4'h0; o.od = 2'b10; o.cs = 1'b0; o.wr = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Inputs are already set; sample mid-cycle, then advance past the next edge.
  task automatic cyc(input string nm, input outs_t e);
    @(negedge Clock);
    chk(nm, 64'(cap()), 64'(e));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input logic st);
    Reset = 1'b1;
    Stall = st;
    cyc("reset_active", idle(3'd0));
    Reset = 1'b0;
    cyc("init_pc_clear", model(3'd0, IR_Out));
    Stall = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input int unsigned pct, input string nm);
    logic [2:0] phs [$];
    int         idx;
    int         guard;
    outs_t      e;
    phs = {3'd1, 3'd2, 3'd3, 3'd4};
    if (ins[15:12] == 4'h1 || ins[15:12] == 4'h2) phs.push_back(3'd5);
    IR_Out = ins;
    idx    = 0;
    guard  = 0;
    while (idx < phs.size()) begin
      Stall = (guard < 40) && ($urandom_range(99) < pct);
      e = Stall ? idle(phs[idx]) : model(phs[idx], ins);
      cyc(nm, e);
      if (!Stall) idx++;
      guard++;
    end
    Stall = 1'b0;
  endtask

  vec_t tab [0:10];

  initial begin
    tab[0]  = '{16'h05A5, 3'd4, 4'b1101, 2'b00, 2'b10, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};
    tab[1]  = '{16'h1240, 3'd4, 4'b1111, 2'b00, 2'b00, 3'b101, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};
    tab[2]  = '{16'h1240, 3'd5, 4'b1110, 2'b01, 2'b10, 3'b111, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 4'h0};
    tab[3]  = '{16'h2100, 3'd5, 4'b1111, 2'b00, 2'b00, 3'b111, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01, 4'h0};
    tab[4]  = '{16'h3B00, 3'd4, 4'b1011, 2'b11, 2'b10, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b10, 4'h4};
    tab[5]  = '{16'h7C00, 3'd4, 4'b0111, 2'b11, 2'b10, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11, 4'h9};
    tab[6]  = '{16'h8000, 3'd4, 4'b1110, 2'b11, 2'b10, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'h2};
    tab[7]  = '{16'h9C00, 3'd4, 4'b0111, 2'b00, 2'b01, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};
    tab[8]  = '{16'hA400, 3'd4, 4'b1101, 2'b00, 2'b00, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};
    tab[9]  = '{16'hB012, 3'd4, 4'b1111, 2'b00, 2'b00, 3'b110, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};
    tab[10] = '{16'hC000, 3'd4, 4'b1111, 2'b00, 2'b00, 3'b111, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'h0};

    @(posedge Clock);
    #1;
    do_reset(1'b0);

    // Vector table: sequence codes every cycle, field values at the listed phase.
    for (int i = 0; i < 11; i++) begin
      int unsigned last;
      last = (tab[i].instr[15:12] == 4'h1 || tab[i].instr[15:12] == 4'h2) ? 5 : 4;
      IR_Out = tab[i].instr;
      for (int unsigned p = 1; p <= last; p++) begin
        @(negedge Clock);
        chk($sformatf("vec%0d_seq", i), 64'(SeqCounter), 64'(p));
        if (p == 32'(tab[i].ph))
          chk($sformatf("vec%0d_fields", i),
              64'({RF_RegSel, MuxASel, RF_FunSel, ARF_RegSel, MuxBSel, Mem_CS, Mem_WR,
                   ARF_OutDSel, RF_OutASel, ALU_FunSel}),
              64'({tab[i].rfr, tab[i].ma, tab[i].rff, tab[i].arfr, tab[i].mb, tab[i].cs,
                   tab[i].wr, tab[i].od, tab[i].oa, tab[i].alu}));
        @(posedge Clock);
        #1;
      end
    end

    // Stall held three cycles in FETCH_L.
    IR_Out = 16'h05A5;
    cyc("stall_fetch_h", model(3'd1, IR_Out));
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall_hold", idle(3'd2));
    Stall = 1'b0;
    cyc("stall_resume", model(3'd2, IR_Out));
    cyc("stall_decode", model(3'd3, IR_Out));
    cyc("stall_exec", model(3'd4, IR_Out));

    // HLT, then 20 cycles parked in HALT with Stall toggling.
    run_instr(16'hF000, 0, "hlt_seq");
    for (int i = 0; i < 20; i++) begin
      Stall = 1'($urandom_range(1));
      cyc("halt_hold", model(3'd7, IR_Out));
    end
    Stall = 1'b0;
    do_reset(1'b1);

    // Reset (together with Stall) during EXEC2 of an LDM.
    IR_Out = 16'h1240;
    for (int unsigned p = 1; p <= 4; p++) cyc("ldm_pre_reset", model(3'(p), IR_Out));
    Reset = 1'b1;
    Stall = 1'b1;
    cyc("reset_mid_ldm", idle(3'd0));
    Reset = 1'b0;
    cyc("reset_pc_clear", model(3'd0, IR_Out));
    Stall = 1'b0;
    cyc("after_reset_fetch", model(3'd1, IR_Out));
    cyc("after_reset_fetch_l", model(3'd2, IR_Out));
    cyc("after_reset_decode", model(3'd3, IR_Out));
    cyc("after_reset_exec1", model(3'd4, IR_Out));
    cyc("after_reset_exec2", model(3'd5, IR_Out));

    // Random instruction stream (HLT excluded) with random stalls.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(14));
      run_instr(ins, 20, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
